// File: rtl/execute_mult_unit.sv
// Execute-stage iterative shift-add multiplier: WIDTH add/shift steps plus one
// sign-fix step, writing the 2*WIDTH-bit product into architectural HI/LO.
module execute_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             StartMultE,
  input  logic             MultSignE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE,
  output logic             MultBusyE,
  output logic             MultDoneE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] res_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;

  // Datapath helpers: step sum, operand magnitudes, sign-corrected product.
  always_comb begin
    sum_s   = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_s  = {acc_q, mplier_q};
    res_s   = neg_q ? (~prod_s + ONE_2W) : prod_s;
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    a_mag_s = (MultSignE && SrcAE[WIDTH-1]) ? (~SrcAE + ONE_W) : SrcAE;
    b_mag_s = (MultSignE && SrcBE[WIDTH-1]) ? (~SrcBE + ONE_W) : SrcBE;
  end

  // Next-state and datapath update for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartMultE) begin
          mcand_d  = a_mag_s;
          mplier_d = b_mag_s;
          neg_d    = MultSignE & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          acc_d    = {WIDTH{1'b0}};
          cnt_d    = CNT_INIT;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = sum_s[WIDTH:1];
        mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        hi_d    = res_s[2*WIDTH-1:WIDTH];
        lo_d    = res_s[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial product.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      neg_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign HiE       = hi_q;
  assign LoE       = lo_q;
  assign MultDoneE = done_q;
  assign MultBusyE = (state_q != IDLE);

endmodule

// File: tb/tb_execute_mult_unit.sv
// Directed bench for execute_mult_unit: hand-computed products, latency,
// busy/done timing, ignored starts, back-to-back issue and async reset.
module tb_execute_mult_unit;

  logic        Clk;
  logic        Rst_n;
  logic        StartMultE;
  logic        MultSignE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [31:0] HiE;
  logic [31:0] LoE;
  logic        MultBusyE;
  logic        MultDoneE;

  int n_cmp;
  int n_bad;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  execute_mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .StartMultE (StartMultE),
    .MultSignE  (MultSignE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .HiE        (HiE),
    .LoE        (LoE),
    .MultBusyE  (MultBusyE),
    .MultDoneE  (MultDoneE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the next edge (E0) and follow it to E33.
  // pulse_at > 0 raises StartMultE with 9*9 before edge E(pulse_at).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int pulse_at);
    StartMultE = 1'b1;
    MultSignE  = sgn;
    SrcAE      = a;
    SrcBE      = b;
    @(posedge Clk);
    #1;
    for (int k = 1; k <= 33; k++) begin
      if (k == pulse_at) begin
        StartMultE = 1'b1;
        SrcAE      = 32'd9;
        SrcBE      = 32'd9;
      end else begin
        StartMultE = 1'b0;
        SrcAE      = 32'hDEAD_BEEF ^ 32'(k);
        SrcBE      = 32'h0F0F_0F0F + 32'(k);
      end
      @(posedge Clk);
      #1;
      if (k < 33) begin
        check_eq({tag, "_busy"}, {63'd0, MultBusyE}, 64'd1);
        check_eq({tag, "_done_early"}, {63'd0, MultDoneE}, 64'd0);
        check_eq({tag, "_hold"}, {HiE, LoE}, {prev_hi, prev_lo});
      end
    end
    StartMultE = 1'b0;
    check_eq({tag, "_busy_end"}, {63'd0, MultBusyE}, 64'd0);
    check_eq({tag, "_done"}, {63'd0, MultDoneE}, 64'd1);
    check_eq({tag, "_hi"}, {32'd0, HiE}, {32'd0, exp[63:32]});
    check_eq({tag, "_lo"}, {32'd0, LoE}, {32'd0, exp[31:0]});
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      check_eq({tag, "_idle_busy"}, {63'd0, MultBusyE}, 64'd0);
      check_eq({tag, "_idle_done"}, {63'd0, MultDoneE}, 64'd0);
      check_eq({tag, "_idle_hilo"}, {HiE, LoE}, {prev_hi, prev_lo});
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    prev_hi    = 32'd0;
    prev_lo    = 32'd0;
    Rst_n      = 1'b0;
    StartMultE = 1'b0;
    MultSignE  = 1'b0;
    SrcAE      = 32'd0;
    SrcBE      = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_hilo", {HiE, LoE}, 64'd0);
    check_eq("rst_busy", {63'd0, MultBusyE}, 64'd0);
    check_eq("rst_done", {63'd0, MultDoneE}, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    idle_cycles("post_rst", 3);

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0);
    idle_cycles("u3x5", 2);
    run_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    idle_cycles("uffxff", 1);
    run_op("u80x2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 0);
    idle_cycles("u80x2", 1);
    run_op("sm2x3", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    idle_cycles("sm2x3", 1);
    run_op("sm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0);
    idle_cycles("sm1xm1", 1);
    run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    idle_cycles("smin2", 1);
    run_op("s100xm7", 32'd100, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FD44, 0);
    idle_cycles("s100xm7", 1);

    run_op("ign7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 10);
    run_op("b2b", 32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, 0);
    idle_cycles("b2b", 2);

    run_op("pre_rst", 32'h0000_0022, 32'h8000_0001, 1'b0, 64'h0000_0011_0000_0022, 0);
    idle_cycles("pre_rst", 1);
    StartMultE = 1'b1;
    MultSignE  = 1'b0;
    SrcAE      = 32'd4;
    SrcBE      = 32'd4;
    @(posedge Clk);
    #1;
    StartMultE = 1'b0;
    for (int k = 1; k < 15; k++) begin
      @(posedge Clk);
    end
    #1;
    check_eq("mid_busy", {63'd0, MultBusyE}, 64'd1);
    check_eq("mid_hold", {HiE, LoE}, 64'h0000_0011_0000_0022);
    Rst_n = 1'b0;
    #1;
    check_eq("arst_hilo", {HiE, LoE}, 64'd0);
    check_eq("arst_busy", {63'd0, MultBusyE}, 64'd0);
    check_eq("arst_done", {63'd0, MultDoneE}, 64'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    idle_cycles("after_arst", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
